// File: rtl/pps_qual_pkg.sv
// pps_qual_pkg -- shared types and helpers for the PPS input qualifier.
//   pps_state_t        : lock state machine encoding (IDLE/ACQ/LOCKED/LOST)
//   QUALITY_LOCK_BASE  : quality floor while LOCKED (selector threshold)
//   QUALITY_MAX_DELTA  : headroom above the floor, reduced by period error
//   sat_inc()          : increment that sticks at a caller-given limit
package pps_qual_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } pps_state_t;

  localparam logic [15:0] QUALITY_LOCK_BASE = 16'h8000;
  localparam logic [15:0] QUALITY_MAX_DELTA = 16'h7FFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/pps_input_qualifier_if.sv
// pps_input_qualifier_if -- PPS qualifier signal bundle.
//   master : drives pps_in/enable, observes qualified outputs (upstream/tb side)
//   slave  : the qualifier itself
//   pps_in, enable                       : raw pin, qualifier enable
//   pps_out, pps_valid, quality          : strobe, lock flag, 16-bit metric
//   period_cycles, period_error          : last period and signed error
//   good_count, pulse_missing, glitch_count
// Optional (PPS_QUAL_STATS_EN): period_min, period_max, bad_period_count.
interface pps_input_qualifier_if;
  logic        pps_in;
  logic        enable;
  logic        pps_out;
  logic        pps_valid;
  logic [15:0] quality;
  logic [31:0] period_cycles;
  logic [31:0] period_error;
  logic [2:0]  good_count;
  logic        pulse_missing;
  logic [15:0] glitch_count;
`ifdef PPS_QUAL_STATS_EN
  logic [31:0] period_min;
  logic [31:0] period_max;
  logic [15:0] bad_period_count;
`endif

  modport master (
    output pps_in, enable,
    input  pps_out, pps_valid, quality, period_cycles, period_error,
           good_count, pulse_missing, glitch_count
`ifdef PPS_QUAL_STATS_EN
    , input period_min, period_max, bad_period_count
`endif
  );

  modport slave (
    input  pps_in, enable,
    output pps_out, pps_valid, quality, period_cycles, period_error,
           good_count, pulse_missing, glitch_count
`ifdef PPS_QUAL_STATS_EN
    , output period_min, period_max, bad_period_count
`endif
  );
endinterface

// File: rtl/pps_glitch_filter.sv
// pps_glitch_filter -- synchronise raw PPS pin, detect rising edge, and
// qualify the pulse by width.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous discard of any in-flight candidate
//   pin        : raw asynchronous PPS input
//   acc        : one-cycle strobe, input stayed high MIN_PULSE_WIDTH cycles
//   glitch     : one-cycle strobe, candidate fell before reaching the width
// Both strobes are combinational from registered state so the pin-to-accept
// delay is exactly 1 + MIN_PULSE_WIDTH clocks.
module pps_glitch_filter #(
  parameter int unsigned MIN_PULSE_WIDTH = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic pin,
  output logic acc,
  output logic glitch
);
  localparam int CW = $clog2(MIN_PULSE_WIDTH + 1);

  // [0],[1] two-flop synchroniser, [2] previous synchronised value
  logic [2:0]    sync;
  logic          rise;
  logic          cand;
  logic [CW-1:0] cnt;   // high cycles seen so far, minus the current one

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[1:0], pin};
  end

  assign rise   = sync[1] & ~sync[2];
  assign acc    = cand & ~clr &  sync[1] & (cnt == CW'(MIN_PULSE_WIDTH - 1));
  assign glitch = cand & ~clr & ~sync[1];

  // The edge cycle counts as the first high cycle, so cnt starts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= 1'b0;
      cnt  <= '0;
    end else if (clr) begin
      cand <= 1'b0;
      cnt  <= '0;
    end else if (!cand) begin
      if (rise) begin
        cand <= 1'b1;
        cnt  <= CW'(1);
      end
    end else if (acc || glitch) begin
      cand <= 1'b0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/pps_input_qualifier.sv
// pps_input_qualifier -- per-source PPS front end feeding the source selector.
// Filters the raw pin, measures edge-to-edge period against CLK_FREQ and runs
// the IDLE/ACQ/LOCKED/LOST lock machine.
//   clk, rst_n : clock, async active-low reset
//   bus        : pps_input_qualifier_if.slave (pin, enable, qualified outputs)
// Build option: PPS_QUAL_STATS_EN adds period_min/period_max/bad_period_count.
module pps_input_qualifier
  import pps_qual_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 100_000_000,
  parameter int unsigned PERIOD_TOL      = 1000,
  parameter int unsigned MIN_PULSE_WIDTH = 10,
  parameter int unsigned GOOD_COUNT_REQ  = 3,
  parameter int unsigned MISSING_TIMEOUT = 150_000_000,
  parameter int unsigned QSHIFT          = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pps_input_qualifier_if.slave  bus
);
  logic        en, acc, glitch;
  pps_state_t  state, state_nx;
  logic [2:0]  gc, gc_nx;
  logic [3:0]  gc_inc;
  logic [31:0] cnt;
  logic [32:0] err33, abs33;
  logic [47:0] sh;
  logic [15:0] delta, q_nx;
  logic        tracking, measuring, good, timeout;

  logic        pps_out_q, valid_q, miss_q;
  logic [15:0] quality_q, glitch_q;
  logic [31:0] period_q, err_q;

  assign en = bus.enable;

  pps_glitch_filter #(.MIN_PULSE_WIDTH(MIN_PULSE_WIDTH)) u_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (~en),
    .pin    (bus.pps_in),
    .acc    (acc),
    .glitch (glitch)
  );

  // cnt = cycles since last accepted edge; on the next accept it equals the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (!en) cnt <= '0;
    else if (acc) cnt <= 32'd1;
    else          cnt <= sat_inc(cnt, 32'hFFFF_FFFF);
  end

  // A period exists only after an edge accepted in ACQ/LOCKED.
  assign tracking  = (state == ACQ) || (state == LOCKED);
  assign measuring = acc && tracking;
  assign err33     = {1'b0, cnt} - 33'(CLK_FREQ);
  assign abs33     = err33[32] ? (~err33 + 33'd1) : err33;
  assign good      = (abs33 <= 33'(PERIOD_TOL));
  assign timeout   = tracking && (cnt > 32'(MISSING_TIMEOUT));
  assign gc_inc    = {1'b0, gc} + 4'd1;

  // Accepted edge is checked before timeout, so an edge in the timeout cycle wins.
  always_comb begin
    state_nx = state;
    gc_nx    = gc;
    unique case (state)
      IDLE, LOST: begin
        if (acc) begin
          state_nx = ACQ;
          gc_nx    = 3'd0;
        end
      end
      ACQ: begin
        if (acc) begin
          if (!good) begin
            gc_nx = 3'd0;
          end else if (gc_inc >= 4'(GOOD_COUNT_REQ)) begin
            state_nx = LOCKED;
            gc_nx    = 3'(GOOD_COUNT_REQ);
          end else begin
            gc_nx = gc_inc[2:0];
          end
        end else if (timeout) begin
          state_nx = LOST;
          gc_nx    = 3'd0;
        end
      end
      LOCKED: begin
        if (acc) begin
          if (!good) begin
            state_nx = ACQ;
            gc_nx    = 3'd0;
          end
        end else if (timeout) begin
          state_nx = LOST;
          gc_nx    = 3'd0;
        end
      end
      default: begin
        state_nx = IDLE;
        gc_nx    = 3'd0;
      end
    endcase
  end

  // LOCKED is only entered on an accepted edge, so abs33 is a fresh measurement.
  always_comb begin
    sh    = {15'd0, abs33} << QSHIFT;
    delta = (sh > 48'h7FFF) ? QUALITY_MAX_DELTA : sh[15:0];
    unique case (state_nx)
      LOCKED:  q_nx = QUALITY_LOCK_BASE + (QUALITY_MAX_DELTA - delta);
      ACQ:     q_nx = {gc_nx, 13'd0};
      default: q_nx = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gc        <= '0;
      pps_out_q <= 1'b0;
      valid_q   <= 1'b0;
      miss_q    <= 1'b0;
      quality_q <= '0;
      period_q  <= '0;
      err_q     <= '0;
      glitch_q  <= '0;
    end else if (!en) begin
      // glitch_q deliberately holds across disable
      state     <= IDLE;
      gc        <= '0;
      pps_out_q <= 1'b0;
      valid_q   <= 1'b0;
      miss_q    <= 1'b0;
      quality_q <= '0;
      period_q  <= '0;
      err_q     <= '0;
    end else begin
      state     <= state_nx;
      gc        <= gc_nx;
      pps_out_q <= acc;
      valid_q   <= (state_nx == LOCKED);
      miss_q    <= (state_nx == LOST);
      if (measuring) begin
        period_q <= cnt;
        err_q    <= err33[31:0];
      end
      if (acc || (state_nx != state)) quality_q <= q_nx;
      if (glitch) glitch_q <= 16'(sat_inc({16'd0, glitch_q}, 32'h0000_FFFF));
    end
  end

  assign bus.pps_out       = pps_out_q;
  assign bus.pps_valid     = valid_q;
  assign bus.quality       = quality_q;
  assign bus.period_cycles = period_q;
  assign bus.period_error  = err_q;
  assign bus.good_count    = gc;
  assign bus.pulse_missing = miss_q;
  assign bus.glitch_count  = glitch_q;

`ifdef PPS_QUAL_STATS_EN
  logic [31:0] pmin_q, pmax_q;
  logic [15:0] bad_q;
  logic        acq_entry;

  assign acq_entry = ((state == IDLE) || (state == LOST)) && (state_nx == ACQ);

  // pmin_q == 0 marks "no period yet"; a measured period is always >= 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmin_q <= '0;
      pmax_q <= '0;
      bad_q  <= '0;
    end else if (!en || acq_entry) begin
      pmin_q <= '0;
      pmax_q <= '0;
      bad_q  <= '0;
    end else if (measuring) begin
      if ((pmin_q == 32'd0) || (cnt < pmin_q)) pmin_q <= cnt;
      if (cnt > pmax_q)                         pmax_q <= cnt;
      if (!good) bad_q <= 16'(sat_inc({16'd0, bad_q}, 32'h0000_FFFF));
    end
  end

  assign bus.period_min       = pmin_q;
  assign bus.period_max       = pmax_q;
  assign bus.bad_period_count = bad_q;
`endif
endmodule

// File: tb/tb_pps_input_qualifier.sv
// tb_pps_input_qualifier -- directed stimulus with a strobe scoreboard.
// Each pulse that should be accepted pushes its expected pps_out cycle and
// output snapshot; a negedge monitor pops and compares on every pps_out.
module tb_pps_input_qualifier;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  typedef struct {
    int          cyc;
    logic [31:0] per;
    logic [31:0] err;
    logic [2:0]  gc;
    logic        valid;
    logic [15:0] q;
    logic        miss;
  } exp_t;

  exp_t sb[$];

  pps_input_qualifier_if bus ();

  pps_input_qualifier #(
    .CLK_FREQ(1000), .PERIOD_TOL(10), .MIN_PULSE_WIDTH(4),
    .GOOD_COUNT_REQ(3), .MISSING_TIMEOUT(1500), .QSHIFT(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] per, input logic [31:0] err,
                              input logic [2:0] gc, input logic valid,
                              input logic [15:0] q, input logic miss);
    exp_t e;
    e.cyc = 0; e.per = per; e.err = err; e.gc = gc;
    e.valid = valid; e.q = q; e.miss = miss;
    return e;
  endfunction

  // Caller is always at posedge+1; advance to the point where cyc == t.
  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pin rises with cyc == t; the strobe is due 2 + MIN_PULSE_WIDTH clocks later.
  task automatic pulse(input int t, input int w, input bit exp_out, input exp_t e);
    wait_until(t);
    bus.pps_in = 1'b1;
    if (exp_out) begin
      e.cyc = t + 6;
      sb.push_back(e);
    end
    wait_until(t + w);
    bus.pps_in = 1'b0;
  endtask

  task automatic check_cleared(input string tag, input logic [15:0] gl);
    check({tag, "_pps_out"}, 32'(bus.pps_out), 32'd0);
    check({tag, "_valid"},   32'(bus.pps_valid), 32'd0);
    check({tag, "_quality"}, 32'(bus.quality), 32'd0);
    check({tag, "_period"},  bus.period_cycles, 32'd0);
    check({tag, "_error"},   bus.period_error, 32'd0);
    check({tag, "_gc"},      32'(bus.good_count), 32'd0);
    check({tag, "_missing"}, 32'(bus.pulse_missing), 32'd0);
    check({tag, "_glitch"},  32'(bus.glitch_count), 32'(gl));
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.pps_out) begin
      if (sb.size() == 0) begin
        check("unexpected_pps_out", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_cycle", 32'(cyc),                e.cyc);
        check("period",       bus.period_cycles,       e.per);
        check("period_error", bus.period_error,        e.err);
        check("good_count",   32'(bus.good_count),     32'(e.gc));
        check("pps_valid",    32'(bus.pps_valid),      32'(e.valid));
        check("quality",      32'(bus.quality),        32'(e.q));
        check("pulse_missing",32'(bus.pulse_missing),  32'(e.miss));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    exp_t none;
    none = mk(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    bus.enable = 1'b1;
    bus.pps_in = 1'b0;
    #1 rst_n = 1'b0;
    wait_until(3);
    check_cleared("reset", 16'd0);
    wait_until(5);
    rst_n = 1'b1;

    // Clean acquisition: 1000-cycle periods, lock on the 4th strobe.
    pulse(20,   20, 1, mk(0,    0, 0, 0, 16'h0000, 0));
    pulse(1020, 20, 1, mk(1000, 0, 1, 0, 16'h2000, 0));
    pulse(2020, 20, 1, mk(1000, 0, 2, 0, 16'h4000, 0));
    pulse(3020, 20, 1, mk(1000, 0, 3, 1, 16'hFFFF, 0));
    pulse(4020, 20, 1, mk(1000, 0, 3, 1, 16'hFFFF, 0));
    // Tolerance edge: +10 stays locked, +11 drops to ACQ.
    pulse(5030, 20, 1, mk(1010, 10, 3, 1, 16'hFF5F, 0));
    pulse(6041, 20, 1, mk(1011, 11, 0, 0, 16'h0000, 0));
    // 3-wide glitch mid-period: counted, no strobe, period unaffected.
    pulse(6541, 3, 0, none);
    wait_until(6600);
    check("glitch_count_after_glitch", 32'(bus.glitch_count), 32'd1);
    pulse(7041, 20, 1, mk(1000, 0, 1, 0, 16'h2000, 0));
    pulse(8041, 20, 1, mk(1000, 0, 2, 0, 16'h4000, 0));
    pulse(9041, 20, 1, mk(1000, 0, 3, 1, 16'hFFFF, 0));
    // Input stops: strobe at 9047, LOST visible 1501 cycles later.
    wait_until(10547);
    check("missing_before_timeout", 32'(bus.pulse_missing), 32'd0);
    check("valid_before_timeout",   32'(bus.pps_valid),     32'd1);
    wait_until(10548);
    check("missing_at_timeout",     32'(bus.pulse_missing), 32'd1);
    check("valid_at_timeout",       32'(bus.pps_valid),     32'd0);
    check("quality_at_timeout",     32'(bus.quality),       32'd0);
    check("gc_at_timeout",          32'(bus.good_count),    32'd0);
    // Recovery edge measures nothing; period registers keep the last value.
    pulse(11000, 20, 1, mk(1000, 0, 0, 0, 16'h0000, 0));
    pulse(12000, 20, 1, mk(1000, 0, 1, 0, 16'h2000, 0));
    pulse(13000, 20, 1, mk(1000, 0, 2, 0, 16'h4000, 0));
    pulse(14000, 20, 1, mk(1000, 0, 3, 1, 16'hFFFF, 0));
    // Edge lands in the timeout cycle: measured (1501, bad), no LOST.
    pulse(15501, 20, 1, mk(1501, 501, 0, 0, 16'h0000, 0));
    pulse(16501, 20, 1, mk(1000, 0, 1, 0, 16'h2000, 0));
    pulse(17501, 20, 1, mk(1000, 0, 2, 0, 16'h4000, 0));
    pulse(18501, 20, 1, mk(1000, 0, 3, 1, 16'hFFFF, 0));
    // Disable while locked: everything clears except glitch_count.
    wait_until(18700);
    bus.enable = 1'b0;
    wait_until(18701);
    check_cleared("disable", 16'd1);
    wait_until(18710);
    bus.enable = 1'b1;
    // Async reset in the middle of a candidate.
    wait_until(18800);
    bus.pps_in = 1'b1;
    wait_until(18804);
    rst_n = 1'b0;
    #1;
    check_cleared("reset_mid_candidate", 16'd0);
    bus.pps_in = 1'b0;
    wait_until(18808);
    rst_n = 1'b1;
    // Fresh start after reset behaves as first edge from IDLE.
    pulse(18900, 20, 1, mk(0, 0, 0, 0, 16'h0000, 0));
    wait_until(19000);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
